// File: rtl/flash_cmd_master_if.sv
// Host command port and SPI flash byte interface of flash_cmd_master.
// The master modport is the command engine; slave is the host/flash side.
interface flash_cmd_master_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_OP;
    logic [23:0] CMD_ADDR;
    logic [8:0]  CMD_LEN;
    logic        WR_REQ;
    logic [7:0]  WR_DATA;
    logic [7:0]  RD_DATA;
    logic        RD_VALID;
    logic        DONE;
    logic        ERR;
    logic        S;
    logic [7:0]  D;
    logic        DATA_DONE;
    logic [7:0]  Q;

    modport master (
        input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_LEN,
        input  WR_DATA, Q,
        output CMD_READY, WR_REQ, RD_DATA, RD_VALID,
        output DONE, ERR, S, D, DATA_DONE
    );

    modport slave (
        output CMD_VALID, CMD_OP, CMD_ADDR, CMD_LEN,
        output WR_DATA, Q,
        input  CMD_READY, WR_REQ, RD_DATA, RD_VALID,
        input  DONE, ERR, S, D, DATA_DONE
    );
endinterface

// File: rtl/flash_cmd_master.sv
// Flash command initiator: frames one host command into S/D/DATA_DONE
// byte slots, optionally wraps write ops in WREN and RDSR WIP polling.
module flash_cmd_master #(
    parameter int STROBE_W  = 2,
    parameter int GAP_W     = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_IDLE   = 4,
    parameter int PAGE_SIZE = 256,
    parameter int AUTO_WREN = 1,
    parameter int POLL_MAX  = 1024
) (
    input logic               CLK,
    input logic               RESET,
    flash_cmd_master_if.master bus
);
    localparam int SLOT_W = STROBE_W + GAP_W;
    localparam int PCW    = $clog2(POLL_MAX) + 1;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_PW    = 8'h0A;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_PE    = 8'hDB;
    localparam logic [7:0] OP_SE    = 8'hD8;
    localparam logic [7:0] OP_DP    = 8'hB9;
    localparam logic [7:0] OP_RDP   = 8'hAB;

    typedef enum logic [2:0] {
        IDLE, CHECK, WREN_FRM, CMD_FRM, POLL_FRM
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_SLOT, PH_HOLD, PH_GAP
    } phase_t;

    state_t           state_q, state_n;
    phase_t           phase_q, phase_n;
    logic [15:0]      cnt_q;
    logic [9:0]       idx_q;
    logic [PCW-1:0]   poll_q;
    logic [7:0]       op_q;
    logic [23:0]      addr_q;
    logic [8:0]       len_q;
    logic             sts_q;
    logic [7:0]       d_q;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic             done_q, done_n;
    logic             err_q, err_n;
    logic             poll_inc;

    logic is_rdid, is_rdsr, is_read, is_fread;
    logic is_pgm, is_ers, is_wr, is_simple;
    logic known, has_addr, has_rd;

    assign is_rdid   = op_q == OP_RDID;
    assign is_rdsr   = op_q == OP_RDSR;
    assign is_read   = op_q == OP_READ;
    assign is_fread  = op_q == OP_FREAD;
    assign is_pgm    = op_q == OP_PP || op_q == OP_PW;
    assign is_ers    = op_q == OP_PE || op_q == OP_SE;
    assign is_wr     = is_pgm || is_ers;
    assign is_simple = op_q == OP_WREN || op_q == OP_WRDI ||
                       op_q == OP_DP   || op_q == OP_RDP;
    assign known     = is_simple || is_rdid || is_rdsr ||
                       is_read || is_fread || is_wr;
    assign has_addr  = is_read || is_fread || is_wr;
    assign has_rd    = is_rdid || is_rdsr || is_read || is_fread;

    logic [9:0]  cmd_slots, nslots, rd_base, nidx;
    logic [15:0] phase_len;
    logic        in_frame, phase_end, last_slot;
    logic        slot_start, slot_end, rd_slot;
    logic        bad_len;
    logic [7:0]  nbyte;

    always_comb begin
        cmd_slots = 10'd1;
        rd_base   = 10'd1;
        unique case (1'b1)
            is_rdsr:  cmd_slots = 10'd2;
            is_rdid:  cmd_slots = 10'd4;
            is_read: begin
                cmd_slots = 10'd4 + {1'b0, len_q};
                rd_base   = 10'd4;
            end
            is_fread: begin
                cmd_slots = 10'd5 + {1'b0, len_q};
                rd_base   = 10'd5;
            end
            is_pgm:   cmd_slots = 10'd4 + {1'b0, len_q};
            is_ers:   cmd_slots = 10'd4;
            default:  cmd_slots = 10'd1;
        endcase
    end

    always_comb begin
        nslots    = 10'd1;
        phase_len = 16'(SLOT_W);
        unique case (state_q)
            POLL_FRM: nslots = 10'd2;
            CMD_FRM:  nslots = cmd_slots;
            default:  nslots = 10'd1;
        endcase
        unique case (phase_q)
            PH_SETUP: phase_len = 16'(CS_SETUP);
            PH_SLOT:  phase_len = 16'(SLOT_W);
            PH_HOLD:  phase_len = 16'(CS_HOLD);
            default:  phase_len = 16'(CS_IDLE);
        endcase
    end

    assign in_frame  = state_q == WREN_FRM || state_q == CMD_FRM ||
                       state_q == POLL_FRM;
    assign phase_end = cnt_q == phase_len - 16'd1;
    assign last_slot = idx_q == nslots - 10'd1;
    assign slot_end  = in_frame && phase_q == PH_SLOT && phase_end;
    assign slot_start = in_frame && phase_end &&
                        (phase_q == PH_SETUP ||
                         (phase_q == PH_SLOT && !last_slot));
    assign nidx      = (phase_q == PH_SETUP) ? 10'd0 : idx_q + 10'd1;
    assign rd_slot   = state_q == CMD_FRM && has_rd && idx_q >= rd_base;
    assign bad_len   = len_q == 9'd0 || 32'(len_q) > PAGE_SIZE;

    // Next slot's byte is loaded at the edge that opens the slot
    always_comb begin
        nbyte = 8'h00;
        unique case (state_q)
            WREN_FRM: nbyte = (nidx == 10'd0) ? OP_WREN : 8'h00;
            POLL_FRM: nbyte = (nidx == 10'd0) ? OP_RDSR : 8'h00;
            CMD_FRM: begin
                if (nidx == 10'd0)
                    nbyte = op_q;
                else if (has_addr && nidx == 10'd1)
                    nbyte = addr_q[23:16];
                else if (has_addr && nidx == 10'd2)
                    nbyte = addr_q[15:8];
                else if (has_addr && nidx == 10'd3)
                    nbyte = addr_q[7:0];
                else if (is_pgm)
                    nbyte = bus.WR_DATA;
            end
            default: nbyte = 8'h00;
        endcase
    end

    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        poll_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.CMD_VALID)
                    state_n = CHECK;
            end
            CHECK: begin
                phase_n = PH_SETUP;
                if (!known || (is_pgm && bad_len)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else if (AUTO_WREN != 0 && is_wr) begin
                    state_n = WREN_FRM;
                end else begin
                    state_n = CMD_FRM;
                end
            end
            default: begin
                if (phase_end) begin
                    unique case (phase_q)
                        PH_SETUP: phase_n = PH_SLOT;
                        PH_SLOT: begin
                            if (last_slot)
                                phase_n = PH_HOLD;
                        end
                        PH_HOLD: phase_n = PH_GAP;
                        default: begin
                            phase_n = PH_SETUP;
                            if (state_q == WREN_FRM) begin
                                state_n = CMD_FRM;
                            end else if (state_q == CMD_FRM) begin
                                if (is_wr) begin
                                    state_n = POLL_FRM;
                                end else begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                end
                            end else if (!sts_q) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else if (poll_q == PCW'(POLL_MAX - 1)) begin
                                state_n = IDLE;
                                err_n   = 1'b1;
                            end else begin
                                poll_inc = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            phase_q    <= PH_SETUP;
            cnt_q      <= 16'd0;
            idx_q      <= 10'd0;
            poll_q     <= '0;
            op_q       <= 8'h00;
            addr_q     <= 24'h0;
            len_q      <= 9'd0;
            sts_q      <= 1'b0;
            d_q        <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            cnt_q      <= (in_frame && !phase_end) ?
                          cnt_q + 16'd1 : 16'd0;
            done_q     <= done_n;
            err_q      <= err_n;
            rd_valid_q <= 1'b0;
            if (state_q == IDLE && bus.CMD_VALID) begin
                op_q   <= bus.CMD_OP;
                addr_q <= bus.CMD_ADDR;
                len_q  <= bus.CMD_LEN;
            end
            if (slot_start) begin
                idx_q <= nidx;
                d_q   <= nbyte;
            end
            if (slot_end) begin
                if (rd_slot) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= bus.Q;
                end
                if (state_q == POLL_FRM)
                    sts_q <= bus.Q[0];
                if (last_slot)
                    d_q <= 8'h00;
            end
            if (state_q == CHECK)
                poll_q <= '0;
            else if (poll_inc)
                poll_q <= poll_q + PCW'(1);
        end
    end

    assign bus.CMD_READY = state_q == IDLE;
    assign bus.S         = !(in_frame && phase_q != PH_GAP);
    assign bus.D         = d_q;
    assign bus.DATA_DONE = in_frame && phase_q == PH_SLOT &&
                           cnt_q < 16'(STROBE_W);
    assign bus.WR_REQ    = slot_start && state_q == CMD_FRM &&
                           is_pgm && nidx >= 10'd4;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_flash_cmd_master.sv
// Directed bench for flash_cmd_master with a slot-indexed Q responder
// and a negedge monitor that logs D bytes, strobes and pulses.
module tb_flash_cmd_master;
    localparam int STROBE_W = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    flash_cmd_master_if bus ();

    flash_cmd_master #(
        .STROBE_W (2),
        .GAP_W    (4),
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .CS_IDLE  (4),
        .PAGE_SIZE(256),
        .AUTO_WREN(1),
        .POLL_MAX (1024)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int nd, nr, nwr, ndone, nerr, nframes, gslot;
    int hi_run, bad_strobe, dd_hi, s_low, ready_busy, cyc;
    bit s_prev, dd_prev;
    logic [7:0] dlog [0:63];
    logic [7:0] rlog [0:15];
    logic [7:0] qtab [0:31];
    logic [7:0] wtab [0:7];
    logic [7:0] q_def;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
        if (s_prev && !bus.S) nframes++;
        if (!bus.S) s_low++;
        if (bus.DATA_DONE) begin
            hi_run++;
            dd_hi++;
        end
        if (dd_prev && !bus.DATA_DONE) begin
            if (hi_run != STROBE_W) bad_strobe++;
            hi_run = 0;
            if (nd < 64) dlog[nd] = bus.D;
            nd++;
            bus.Q = (gslot < 32) ? qtab[gslot] : q_def;
            gslot++;
        end
        if (bus.RD_VALID) begin
            if (nr < 16) rlog[nr] = bus.RD_DATA;
            nr++;
        end
        if (bus.WR_REQ) begin
            bus.WR_DATA = wtab[nwr % 8];
            nwr++;
        end
        if (bus.DONE) ndone++;
        if (bus.ERR) nerr++;
        s_prev  = bus.S;
        dd_prev = bus.DATA_DONE;
    endtask

    task automatic clr(input logic [7:0] qd);
        nd = 0; nr = 0; nwr = 0; ndone = 0; nerr = 0;
        nframes = 0; gslot = 0; hi_run = 0; bad_strobe = 0;
        dd_hi = 0; s_low = 0; ready_busy = 0;
        q_def = qd;
        bus.Q = qd;
        for (int i = 0; i < 32; i++) qtab[i] = qd;
    endtask

    task automatic run(input logic [7:0] op, input logic [23:0] addr,
                       input logic [8:0] len, input int budget);
        bus.CMD_OP    = op;
        bus.CMD_ADDR  = addr;
        bus.CMD_LEN   = len;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        cyc = 0;
        while (ndone == 0 && nerr == 0 && cyc < budget) begin
            tick();
            cyc++;
            if (bus.CMD_READY && !bus.DONE && !bus.ERR)
                ready_busy++;
        end
        chk("complete_in_budget", 32'(cyc < budget), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 8'h00;
        bus.CMD_ADDR  = 24'h0;
        bus.CMD_LEN   = 9'd0;
        bus.WR_DATA   = 8'h00;
        for (int i = 0; i < 8; i++) wtab[i] = 8'h00;
        clr(8'h00);
        repeat (3) tick();
        chk("rst_S", 32'(bus.S), 32'd1);
        chk("rst_D", 32'(bus.D), 32'h0);
        chk("rst_DATA_DONE", 32'(bus.DATA_DONE), 32'd0);
        chk("rst_CMD_READY", 32'(bus.CMD_READY), 32'd1);
        chk("rst_pulses", {28'd0, bus.WR_REQ, bus.RD_VALID,
                           bus.DONE, bus.ERR}, 32'd0);
        chk("rst_RD_DATA", 32'(bus.RD_DATA), 32'h0);
        RESET = 1'b0;
        repeat (2) tick();

        // RDID
        clr(8'h00);
        qtab[1] = 8'hC2; qtab[2] = 8'h20; qtab[3] = 8'h16;
        run(8'h9F, 24'h0, 9'd0, 2000);
        chk("rdid_frames", nframes, 1);
        chk("rdid_nbytes", nd, 4);
        chk("rdid_D", {dlog[0], dlog[1], dlog[2], dlog[3]}, 32'h9F000000);
        chk("rdid_nrd", nr, 3);
        chk("rdid_rd", {8'h0, rlog[0], rlog[1], rlog[2]}, 32'hC22016);
        chk("rdid_done", {ndone[15:0], nerr[15:0]}, 32'h00010000);
        chk("rdid_ready_busy", ready_busy, 0);
        chk("rdid_strobe", bad_strobe, 0);

        // PP with auto WREN and three polls
        clr(8'h00);
        qtab[8] = 8'h01; qtab[10] = 8'h01; qtab[12] = 8'h00;
        wtab[0] = 8'hA5; wtab[1] = 8'h3C;
        run(8'h02, 24'h000100, 9'd2, 5000);
        chk("pp_frames", nframes, 5);
        chk("pp_nbytes", nd, 13);
        chk("pp_wren", 32'(dlog[0]), 32'h06);
        chk("pp_hdr", {dlog[1], dlog[2], dlog[3], dlog[4]}, 32'h02000100);
        chk("pp_data", {16'h0, dlog[5], dlog[6]}, 32'hA53C);
        chk("pp_poll_a", {dlog[7], dlog[8], dlog[9], dlog[10]},
            32'h05000500);
        chk("pp_poll_b", {16'h0, dlog[11], dlog[12]}, 32'h0500);
        chk("pp_wrreq", nwr, 2);
        chk("pp_nrd", nr, 0);
        chk("pp_done", {ndone[15:0], nerr[15:0]}, 32'h00010000);

        // READ across a 64K boundary
        clr(8'h00);
        qtab[4] = 8'h11; qtab[5] = 8'h22; qtab[6] = 8'h33;
        run(8'h03, 24'h0FFFFE, 9'd3, 2000);
        chk("read_nbytes", nd, 7);
        chk("read_hdr", {dlog[0], dlog[1], dlog[2], dlog[3]}, 32'h030FFFFE);
        chk("read_dummy", {8'h0, dlog[4], dlog[5], dlog[6]}, 32'h0);
        chk("read_rd", {8'h0, rlog[0], rlog[1], rlog[2]}, 32'h112233);
        chk("read_nrd", nr, 3);
        chk("read_strobe", bad_strobe, 0);
        chk("read_done", {ndone[15:0], nerr[15:0]}, 32'h00010000);

        // READ with zero length
        clr(8'h00);
        run(8'h03, 24'h123456, 9'd0, 2000);
        chk("read0_nbytes", nd, 4);
        chk("read0_hdr", {dlog[0], dlog[1], dlog[2], dlog[3]}, 32'h03123456);
        chk("read0_nrd", nr, 0);
        chk("read0_done", ndone, 1);

        // FAST_READ: the extra dummy byte is discarded
        clr(8'h00);
        qtab[4] = 8'hEE; qtab[5] = 8'h5A;
        run(8'h0B, 24'h000020, 9'd1, 2000);
        chk("fread_nbytes", nd, 6);
        chk("fread_hdr", {dlog[0], dlog[1], dlog[2], dlog[3]}, 32'h0B000020);
        chk("fread_nrd", nr, 1);
        chk("fread_rd", 32'(rlog[0]), 32'h5A);

        // unknown opcode
        clr(8'h00);
        run(8'h77, 24'h0, 9'd0, 50);
        chk("badop_latency", cyc, 1);
        chk("badop_err", {ndone[15:0], nerr[15:0]}, 32'h00000001);
        chk("badop_S_low", s_low, 0);
        chk("badop_dd", dd_hi, 0);

        // PP length out of range
        clr(8'h00);
        run(8'h02, 24'h0, 9'd300, 50);
        chk("pp300_err", {ndone[15:0], nerr[15:0]}, 32'h00000001);
        chk("pp300_frames", nframes, 0);
        clr(8'h00);
        run(8'h02, 24'h0, 9'd0, 50);
        chk("pp0_err", nerr, 1);
        chk("pp0_frames", nframes, 0);

        // SE with WIP stuck high: poll timeout
        clr(8'h01);
        run(8'hD8, 24'h010000, 9'd0, 40000);
        chk("se_err", {ndone[15:0], nerr[15:0]}, 32'h00000001);
        chk("se_frames", nframes, 1026);
        chk("se_ops", {16'h0, dlog[0], dlog[1]}, 32'h06D8);

        // reset during a READ address slot
        clr(8'h00);
        bus.CMD_OP    = 8'h03;
        bus.CMD_ADDR  = 24'hABCDEF;
        bus.CMD_LEN   = 9'd4;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        cyc = 0;
        while (nd < 2 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rstmid_reach", 32'(cyc < 200), 32'd1);
        RESET = 1'b1;
        tick();
        chk("rstmid_S", 32'(bus.S), 32'd1);
        chk("rstmid_DATA_DONE", 32'(bus.DATA_DONE), 32'd0);
        chk("rstmid_D", 32'(bus.D), 32'h0);
        chk("rstmid_CMD_READY", 32'(bus.CMD_READY), 32'd1);
        RESET = 1'b0;
        repeat (30) tick();
        chk("rstmid_no_pulse", {ndone[15:0], nerr[15:0]}, 32'h0);
        chk("rstmid_idle_S", 32'(bus.S), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
